id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 SHALL have parameter LANES, default 2, number of issue lanes moved as one bundle (legal 1..4).
REQ-002 SHALL have parameter XLEN, default 32, width of pc/instr fields.
REQ-003 SHALL have parameter PAY_W, default 128, per-lane payload (reg1, reg2, immed, rd/rs1/rs2, control).
REQ-004 SHALL have parameter DEPTH, default 2, bundle storage entries (legal 1 or 2).
REQ-005 SHALL have one clock and an asynchronous, active-low reset:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- ACT  in  1  upstream bundle offered (ID stage active).
- in_valid  in  LANES  per-lane instruction valid.
- in_pc  in  LANES*XLEN  per-lane pc.
- in_instr  in  LANES*XLEN  per-lane instruction word.
- in_order  in  LANES  per-lane order bit.
- in_payload  in  LANES*PAY_W  per-lane payload.
- in_ready  out  1  bundle can be accepted this cycle.
- ex_ready  in  1  EX consumes the head bundle this cycle.
- flush  in  1  discard all held and offered bundles.
- out_valid  out  LANES  head-bundle lane valids.
- out_pc, out_instr, out_order, out_payload  out  same widths as the inputs  head-bundle fields.
- count  out  2  bundles held (0..DEPTH).
- pres_valid  out  1  preserved record holds data.
- pres_pc  out  XLEN  preserved oldest-lane pc.
- pres_instr  out  XLEN  preserved oldest-lane instruction.
- pres_order  out  1  preserved oldest-lane order bit.

Function
REQ-006 SHALL accept a bundle when ACT=1, in_ready=1, flush=0 and in_valid is nonzero; a bundle with in_valid all-zero SHALL NOT be stored.
REQ-007 SHALL store bundles FIFO; out_* SHALL always reflect the oldest held bundle, or zeros (out_valid=0) when count=0.
REQ-008 SHALL present an accepted bundle on out_* the cycle after acceptance when count was 0 (latency 1, no combinational in-to-out path).
REQ-009 Head SHALL be consumed at the edge where ex_ready=1 and count>0; ex_ready with count=0 SHALL have no effect.
REQ-010 DEPTH=2: in_ready SHALL be (count<2), a function of registered state only.
REQ-011 DEPTH=1: in_ready SHALL be (count==0) OR ex_ready.
REQ-012 Accept and consume in the same cycle SHALL leave count unchanged, with the new bundle behind any remaining one.
REQ-013 flush=1 SHALL set count to 0 and out_valid to 0 at the next edge; the same-cycle offered bundle SHALL be dropped; flush has priority over accept and consume.
REQ-014 On each accept, pres_* SHALL capture pc/instr/order of the lowest-index lane with in_valid=1, and pres_valid SHALL be set to 1.
REQ-015 pres_* SHALL hold when no accept occurs; flush SHALL NOT alter pres_*.
REQ-016 Per-lane fields SHALL be carried unmodified, lane i in bits [i*W +: W].
REQ-017 count SHALL never exceed DEPTH or wrap below 0; both pointers SHALL wrap modulo DEPTH.

Reset
REQ-018 While RST=0 (asynchronously): count=0, out_valid=0, all out_* data=0, pres_valid=0, pres_*=0.
REQ-019 While RST=0, in_ready SHALL be 1; an offer during reset SHALL NOT be stored.
REQ-020 Reset asserted mid-operation SHALL discard all held bundles; the first edge after release SHALL behave as if from empty.

Verification
REQ-021 Basic pass:
- Stimulus: DEPTH=2, ACT=1, in_valid=2'b11, in_pc={0x104,0x100}, ex_ready=1.
- Response: next cycle out_valid=11, out_pc={0x104,0x100}, count=1, pres_pc=0x100.
REQ-022 Backpressure:
- Stimulus: ex_ready=0, three consecutive offers A, B, C.
- Response: A and B held, count=2, in_ready=0, C not accepted; when ex_ready=1, out_* gives A then B.
REQ-023 Flush priority:
- Stimulus: count=2, flush=1 with ACT=1 and ex_ready=1 in the same cycle.
- Response: next cycle count=0, out_valid=0, pres_* unchanged.
REQ-024 Oldest-lane capture:
- Stimulus: in_valid=2'b10, lane1 pc=0x200.
- Response: pres_pc=0x200, pres_valid=1; a following all-zero in_valid offer is not stored and count is unchanged.
REQ-025 DEPTH=1 pass-through ready:
- Stimulus: count=1, ex_ready=1, new offer D.
- Response: in_ready=1 that cycle; next cycle out_* gives D and count=1.
REQ-026 Reset mid-run:
- Stimulus: RST=0 pulsed between edges with count=2.
- Response: out_valid=0 and count=0 immediately, before the next edge.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX bundle handshake: upstream offer, EX consume/flush, head-bundle view
// and the preserved oldest-lane record.
interface id_ex_pipe_reg_if #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int PAY_W = 128
) ();
    logic                             ACT;
    logic [LANES-1:0]                 in_valid;
    logic [LANES-1:0][XLEN-1:0]       in_pc;
    logic [LANES-1:0][XLEN-1:0]       in_instr;
    logic [LANES-1:0]                 in_order;
    logic [LANES-1:0][PAY_W-1:0]      in_payload;
    logic                             in_ready;
    logic                             ex_ready;
    logic                             flush;
    logic [LANES-1:0]                 out_valid;
    logic [LANES-1:0][XLEN-1:0]       out_pc;
    logic [LANES-1:0][XLEN-1:0]       out_instr;
    logic [LANES-1:0]                 out_order;
    logic [LANES-1:0][PAY_W-1:0]      out_payload;
    logic [1:0]                       count;
    logic                             pres_valid;
    logic [XLEN-1:0]                  pres_pc;
    logic [XLEN-1:0]                  pres_instr;
    logic                             pres_order;

    modport slave (
        input  ACT, in_valid, in_pc, in_instr, in_order, in_payload, ex_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_order, out_payload, count,
               pres_valid, pres_pc, pres_instr, pres_order
    );

    modport master (
        output ACT, in_valid, in_pc, in_instr, in_order, in_payload, ex_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_order, out_payload, count,
               pres_valid, pres_pc, pres_instr, pres_order
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: a 1- or 2-entry FIFO of multi-lane issue bundles,
// plus a record of the oldest valid lane of the most recently accepted bundle.

module id_ex_pipe_reg_lane #(
    parameter int XLEN  = 32,
    parameter int PAY_W = 128
) (
    input  logic             en,
    input  logic             vld_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic             order_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic             vld_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  instr_o,
    output logic             order_o,
    output logic [PAY_W-1:0] pay_o
);
    // Head fields read as zero whenever the FIFO is empty.
    assign vld_o   = en & vld_i;
    assign pc_o    = en ? pc_i    : '0;
    assign instr_o = en ? instr_i : '0;
    assign order_o = en & order_i;
    assign pay_o   = en ? pay_i   : '0;
endmodule

module id_ex_pipe_reg #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int PAY_W = 128,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    id_ex_pipe_reg_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [LANES-1:0]            vld;
        logic [LANES-1:0][XLEN-1:0]  pc;
        logic [LANES-1:0][XLEN-1:0]  instr;
        logic [LANES-1:0]            order;
        logic [LANES-1:0][PAY_W-1:0] pay;
    } bundle_t;

    bundle_t          mem_q [DEPTH];
    bundle_t          mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pres_valid_q, pres_valid_d;
    logic [XLEN-1:0]  pres_pc_q, pres_pc_d;
    logic [XLEN-1:0]  pres_instr_q, pres_instr_d;
    logic             pres_order_q, pres_order_d;

    logic    in_ready;
    logic    accept;
    logic    consume;
    logic    head_en;
    bundle_t offer;
    bundle_t head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Single-entry build relies on same-cycle drain to keep a bubble-free stream;
    // the two-entry build keeps in_ready off the EX path entirely.
    generate
        if (DEPTH == 1) begin : g_rdy_d1
            assign in_ready = (count_q == 2'd0) || bus.ex_ready;
        end else begin : g_rdy_d2
            assign in_ready = (count_q < 2'd2);
        end
    endgenerate

    assign accept  = bus.ACT && in_ready && !bus.flush && (bus.in_valid != '0);
    assign consume = bus.ex_ready && (count_q != 2'd0) && !bus.flush;
    assign head_en = (count_q != 2'd0);

    always_comb begin
        offer.vld   = bus.in_valid;
        offer.pc    = bus.in_pc;
        offer.instr = bus.in_instr;
        offer.order = bus.in_order;
        offer.pay   = bus.in_payload;
        head        = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        pres_valid_d = pres_valid_q;
        pres_pc_d    = pres_pc_q;
        pres_instr_d = pres_instr_q;
        pres_order_d = pres_order_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 2'd0;
        end else begin
            if (accept) begin
                mem_d[wr_ptr_q] = offer;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (consume) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + 2'(accept) - 2'(consume);
        end

        if (accept) begin
            pres_valid_d = 1'b1;
            // Walk high-to-low so the lowest valid lane wins.
            for (int i = LANES - 1; i >= 0; i--) begin
                if (bus.in_valid[i]) begin
                    pres_pc_d    = bus.in_pc[i];
                    pres_instr_d = bus.in_instr[i];
                    pres_order_d = bus.in_order[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= 2'd0;
            pres_valid_q <= 1'b0;
            pres_pc_q    <= '0;
            pres_instr_q <= '0;
            pres_order_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pres_valid_q <= pres_valid_d;
            pres_pc_q    <= pres_pc_d;
            pres_instr_q <= pres_instr_d;
            pres_order_q <= pres_order_d;
        end
    end

    logic [LANES-1:0]            out_valid_w;
    logic [LANES-1:0][XLEN-1:0]  out_pc_w;
    logic [LANES-1:0][XLEN-1:0]  out_instr_w;
    logic [LANES-1:0]            out_order_w;
    logic [LANES-1:0][PAY_W-1:0] out_pay_w;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            id_ex_pipe_reg_lane #(
                .XLEN  (XLEN),
                .PAY_W (PAY_W)
            ) u_lane (
                .en      (head_en),
                .vld_i   (head.vld[g]),
                .pc_i    (head.pc[g]),
                .instr_i (head.instr[g]),
                .order_i (head.order[g]),
                .pay_i   (head.pay[g]),
                .vld_o   (out_valid_w[g]),
                .pc_o    (out_pc_w[g]),
                .instr_o (out_instr_w[g]),
                .order_o (out_order_w[g]),
                .pay_o   (out_pay_w[g])
            );
        end
    endgenerate

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_pc      = out_pc_w;
    assign bus.out_instr   = out_instr_w;
    assign bus.out_order   = out_order_w;
    assign bus.out_payload = out_pay_w;
    assign bus.count       = count_q;
    assign bus.pres_valid  = pres_valid_q;
    assign bus.pres_pc     = pres_pc_q;
    assign bus.pres_instr  = pres_instr_q;
    assign bus.pres_order  = pres_order_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: DEPTH=2 and DEPTH=1 instances share stimulus and
// are checked against queue-based reference models, plus a directed table.
module tb_id_ex_pipe_reg;
    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int PAY_W = 128;

    typedef struct packed {
        logic [LANES-1:0]            vld;
        logic [LANES-1:0][XLEN-1:0]  pc;
        logic [LANES-1:0][XLEN-1:0]  instr;
        logic [LANES-1:0]            order;
        logic [LANES-1:0][PAY_W-1:0] pay;
    } bun_t;

    typedef struct {
        logic        act;
        logic [1:0]  vld;
        logic [31:0] pc0, pc1;
        logic        exr, fl;
        logic        rdy;
        logic [1:0]  ov;
        logic [31:0] opc0, opc1;
        logic [1:0]  cnt;
        logic        pv;
        logic [31:0] ppc;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    id_ex_pipe_reg_if #(.LANES(LANES), .XLEN(XLEN), .PAY_W(PAY_W)) b2 ();
    id_ex_pipe_reg_if #(.LANES(LANES), .XLEN(XLEN), .PAY_W(PAY_W)) b1 ();

    id_ex_pipe_reg #(.LANES(LANES), .XLEN(XLEN), .PAY_W(PAY_W), .DEPTH(2)) u_d2 (
        .CLK(CLK), .RST(RST), .bus(b2));
    id_ex_pipe_reg #(.LANES(LANES), .XLEN(XLEN), .PAY_W(PAY_W), .DEPTH(1)) u_d1 (
        .CLK(CLK), .RST(RST), .bus(b1));

    int n_pass = 0;
    int n_tot  = 0;

    bun_t        cur;
    logic        c_act, c_exr, c_fl;
    bun_t        q2[$];
    bun_t        q1[$];
    logic        pv_m   [2];
    logic [31:0] ppc_m  [2];
    logic [31:0] pin_m  [2];
    logic        pord_m [2];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic bun_t mk(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
        bun_t b;
        b.vld      = v;
        b.pc[0]    = p0;
        b.pc[1]    = p1;
        b.instr[0] = p0 ^ 32'h1357_0000;
        b.instr[1] = p1 ^ 32'h1357_0000;
        b.order[0] = p0[3];
        b.order[1] = p1[3];
        b.pay[0]   = {4{p0}};
        b.pay[1]   = {4{~p1}};
        return b;
    endfunction

    function automatic bun_t rnd_bun();
        bun_t b;
        b.vld = 2'($urandom_range(0, 3));
        for (int i = 0; i < LANES; i++) begin
            b.pc[i]    = $urandom;
            b.instr[i] = $urandom;
            b.order[i] = 1'($urandom_range(0, 1));
            b.pay[i]   = {$urandom, $urandom, $urandom, $urandom};
        end
        return b;
    endfunction

    task automatic apply(input bun_t b, input logic act, input logic exr, input logic fl);
        cur = b; c_act = act; c_exr = exr; c_fl = fl;
        b2.ACT = act; b2.in_valid = b.vld; b2.in_pc = b.pc; b2.in_instr = b.instr;
        b2.in_order = b.order; b2.in_payload = b.pay; b2.ex_ready = exr; b2.flush = fl;
        b1.ACT = act; b1.in_valid = b.vld; b1.in_pc = b.pc; b1.in_instr = b.instr;
        b1.in_order = b.order; b1.in_payload = b.pay; b1.ex_ready = exr; b1.flush = fl;
    endtask

    task automatic m_reset();
        q2.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            pv_m[d] = 1'b0; ppc_m[d] = '0; pin_m[d] = '0; pord_m[d] = 1'b0;
        end
    endtask

    function automatic logic m_ready(input int d);
        if (d == 0) return q2.size() < 2;
        return (q1.size() == 0) || c_exr;
    endfunction

    // One clock edge of the reference: flush empties, else pop head on EX
    // demand and append the offered bundle if it was admissible.
    task automatic m_step();
        logic acc;
        for (int d = 0; d < 2; d++) begin
            acc = c_act && m_ready(d) && !c_fl && (cur.vld != '0);
            if (c_fl) begin
                if (d == 0) q2.delete(); else q1.delete();
            end else begin
                if (c_exr && d == 0 && q2.size() > 0) void'(q2.pop_front());
                if (c_exr && d == 1 && q1.size() > 0) void'(q1.pop_front());
                if (acc) begin
                    if (d == 0) q2.push_back(cur); else q1.push_back(cur);
                end
            end
            if (acc) begin
                pv_m[d] = 1'b1;
                for (int i = LANES - 1; i >= 0; i--) begin
                    if (cur.vld[i]) begin
                        ppc_m[d] = cur.pc[i]; pin_m[d] = cur.instr[i]; pord_m[d] = cur.order[i];
                    end
                end
            end
        end
    endtask

    task automatic chk_dut(input int d);
        bun_t o, e;
        logic [1:0] cnt;
        logic [65:0] pres;
        int n;
        if (d == 0) begin
            o.vld = b2.out_valid; o.pc = b2.out_pc; o.instr = b2.out_instr;
            o.order = b2.out_order; o.pay = b2.out_payload; cnt = b2.count;
            pres = {b2.pres_valid, b2.pres_pc, b2.pres_instr, b2.pres_order};
            n = q2.size(); e = (n > 0) ? q2[0] : '0;
        end else begin
            o.vld = b1.out_valid; o.pc = b1.out_pc; o.instr = b1.out_instr;
            o.order = b1.out_order; o.pay = b1.out_payload; cnt = b1.count;
            pres = {b1.pres_valid, b1.pres_pc, b1.pres_instr, b1.pres_order};
            n = q1.size(); e = (n > 0) ? q1[0] : '0;
        end
        chk($sformatf("depth%0d out_bundle", 2 - d), 512'(o), 512'(e));
        chk($sformatf("depth%0d count", 2 - d), 512'(cnt), 512'(n));
        chk($sformatf("depth%0d pres", 2 - d), 512'(pres),
            512'({pv_m[d], ppc_m[d], pin_m[d], pord_m[d]}));
    endtask

    // Caller has applied inputs; check readiness, advance one edge, check outputs.
    task automatic step();
        #1;
        chk("depth2 in_ready", 512'(b2.in_ready), 512'(m_ready(0)));
        chk("depth1 in_ready", 512'(b1.in_ready), 512'(m_ready(1)));
        m_step();
        @(posedge CLK);
        #1;
        chk_dut(0);
        chk_dut(1);
    endtask

    vec_t tbl[14];
    bun_t tmp;

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 2'b11, 32'h100, 32'h104, 2'd1, 1'b1, 32'h100};
        tbl[1]  = '{1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 1'b1, 32'h100};
        tbl[2]  = '{1'b1, 2'b11, 32'h300, 32'h304, 1'b0, 1'b0, 1'b1, 2'b11, 32'h300, 32'h304, 2'd1, 1'b1, 32'h300};
        tbl[3]  = '{1'b1, 2'b01, 32'h310, 32'h314, 1'b0, 1'b0, 1'b1, 2'b11, 32'h300, 32'h304, 2'd2, 1'b1, 32'h310};
        tbl[4]  = '{1'b1, 2'b11, 32'h320, 32'h324, 1'b0, 1'b0, 1'b0, 2'b11, 32'h300, 32'h304, 2'd2, 1'b1, 32'h310};
        tbl[5]  = '{1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 2'b01, 32'h310, 32'h314, 2'd1, 1'b1, 32'h310};
        tbl[6]  = '{1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 1'b1, 32'h310};
        tbl[7]  = '{1'b1, 2'b11, 32'h400, 32'h404, 1'b0, 1'b0, 1'b1, 2'b11, 32'h400, 32'h404, 2'd1, 1'b1, 32'h400};
        tbl[8]  = '{1'b1, 2'b11, 32'h410, 32'h414, 1'b0, 1'b0, 1'b1, 2'b11, 32'h400, 32'h404, 2'd2, 1'b1, 32'h410};
        tbl[9]  = '{1'b1, 2'b11, 32'h420, 32'h424, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'd0, 1'b1, 32'h410};
        tbl[10] = '{1'b1, 2'b11, 32'h430, 32'h434, 1'b0, 1'b0, 1'b1, 2'b11, 32'h430, 32'h434, 2'd1, 1'b1, 32'h430};
        tbl[11] = '{1'b1, 2'b11, 32'h440, 32'h444, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 1'b1, 32'h430};
        tbl[12] = '{1'b1, 2'b10, 32'h1f0, 32'h200, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1f0, 32'h200, 2'd1, 1'b1, 32'h200};
        tbl[13] = '{1'b1, 2'b00, 32'h500, 32'h504, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1f0, 32'h200, 2'd1, 1'b1, 32'h200};

        // Reset with an offer pending: ready high, nothing stored.
        m_reset();
        apply(mk(2'b11, 32'hbad0, 32'hbad4), 1'b1, 1'b0, 1'b0);
        #1;
        chk("reset in_ready depth2", 512'(b2.in_ready), 512'(1'b1));
        chk("reset in_ready depth1", 512'(b1.in_ready), 512'(1'b1));
        chk_dut(0);
        chk_dut(1);
        @(posedge CLK);
        #1;
        chk_dut(0);
        chk_dut(1);
        RST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply(mk(tbl[i].vld, tbl[i].pc0, tbl[i].pc1), tbl[i].act, tbl[i].exr, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d in_ready", i), 512'(b2.in_ready), 512'(tbl[i].rdy));
            step();
            chk($sformatf("tbl%0d out_valid", i), 512'(b2.out_valid), 512'(tbl[i].ov));
            chk($sformatf("tbl%0d out_pc", i), 512'(b2.out_pc), 512'({tbl[i].opc1, tbl[i].opc0}));
            chk($sformatf("tbl%0d count", i), 512'(b2.count), 512'(tbl[i].cnt));
            chk($sformatf("tbl%0d pres", i), 512'({b2.pres_valid, b2.pres_pc}),
                512'({tbl[i].pv, tbl[i].ppc}));
        end

        // Single-entry pass-through: full register still accepts when EX drains.
        apply(mk(2'b00, 32'h0, 32'h0), 1'b0, 1'b0, 1'b1);
        step();
        apply(mk(2'b11, 32'h600, 32'h604), 1'b1, 1'b0, 1'b0);
        step();
        apply(mk(2'b11, 32'h610, 32'h614), 1'b1, 1'b1, 1'b0);
        #1;
        chk("depth1 passthru in_ready", 512'(b1.in_ready), 512'(1'b1));
        step();
        chk("depth1 passthru out_pc", 512'(b1.out_pc), 512'({32'h614, 32'h610}));
        chk("depth1 passthru count", 512'(b1.count), 512'(2'd1));

        for (int k = 0; k < 400; k++) begin
            apply(rnd_bun(), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
            step();
        end

        // Asynchronous reset pulse between edges with two bundles held.
        apply(mk(2'b00, 32'h0, 32'h0), 1'b0, 1'b0, 1'b1);
        step();
        apply(mk(2'b11, 32'h700, 32'h704), 1'b1, 1'b0, 1'b0);
        step();
        apply(mk(2'b01, 32'h710, 32'h714), 1'b1, 1'b0, 1'b0);
        step();
        chk("prereset count", 512'(b2.count), 512'(2'd2));
        RST = 1'b0;
        #1;
        m_reset();
        chk("async rst count", 512'(b2.count), 512'(2'd0));
        chk("async rst out_valid", 512'(b2.out_valid), 512'(2'b00));
        chk_dut(0);
        chk_dut(1);
        #2;
        RST = 1'b1;
        apply(mk(2'b10, 32'h800, 32'h804), 1'b1, 1'b0, 1'b0);
        step();
        chk("post reset out_pc", 512'(b2.out_pc), 512'({32'h804, 32'h800}));
        chk("post reset pres_pc", 512'(b2.pres_pc), 512'(32'h804));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
